layer_seq_ctrl: RTL and testbench

- Sequencer for a time-multiplexed, masked fully-connected layer datapath of INPUT_SIZE inputs and OUTPUT_SIZE neurons.
- Per neuron, the block performs these steps in order:
  - requests fresh mask randomness from the mask source;
  - clears the masked accumulator;
  - steps the input/weight index through all inputs;
  - adds the bias;
  - writes the neuron result.
- Sits between the top-level inference control and the layer's MAC/adder-tree datapath, weight/bias storage and mask PRNG.

---
 rtl/layer_seq_ctrl.sv | 167 ++++++++++++++++
 tb/tb_layer_seq_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/layer_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : layer_seq_ctrl
// Purpose  : Sequencer for a time-multiplexed, masked fully-connected layer.
//            For each neuron it requests fresh mask shares, clears the
//            accumulator, steps through all inputs, adds the bias, and
//            writes the neuron result.
// Ports    : clk, rst       - clock, synchronous active-high reset
//            start          - begin one layer evaluation (sampled in IDLE)
//            hold           - datapath stall, freezes MAC stepping
//            mask_ack       - mask source has fresh shares this cycle
//            busy, done     - evaluation in progress / 1-cycle completion
//            mask_req       - request fresh mask shares
//            mask_load      - datapath latches mask shares this cycle
//            mac_clr        - clear accumulator shares
//            mac_en         - accumulate inputs[in_idx]*w[out_idx][in_idx]
//            bias_en        - add b[out_idx]
//            out_we         - write accumulator to outputs[out_idx]
//            in_idx,out_idx - current input column / neuron index
// Revision : 1.0 - initial release
// ============================================================================
module layer_seq_ctrl #(
   parameter int INPUT_SIZE  = 10,
   parameter int OUTPUT_SIZE = 10,
   parameter int IDX_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             hold,
   input  logic             mask_ack,
   output logic             busy,
   output logic             done,
   output logic             mask_req,
   output logic             mask_load,
   output logic             mac_clr,
   output logic             mac_en,
   output logic             bias_en,
   output logic             out_we,
   output logic [IDX_W-1:0] in_idx,
   output logic [IDX_W-1:0] out_idx
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MASK  = 3'd1,
      CLEAR = 3'd2,
      MAC   = 3'd3,
      BIAS  = 3'd4,
      WRITE = 3'd5,
      DONE  = 3'd6
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(INPUT_SIZE - 1);
   localparam logic [IDX_W-1:0] LAST_OUT = IDX_W'(OUTPUT_SIZE - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] in_cnt, in_nxt;
   logic [IDX_W-1:0] out_cnt, out_nxt;

   // Ungated strobe decodes; masked by rst below.
   logic busy_d, done_d, req_d, load_d, clr_d, mac_d, bias_d, we_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         in_cnt  <= '0;
         out_cnt <= '0;
      end else begin
         state   <= state_nxt;
         in_cnt  <= in_nxt;
         out_cnt <= out_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_nxt    = in_cnt;
      out_nxt   = out_cnt;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      req_d     = 1'b0;
      load_d    = 1'b0;
      clr_d     = 1'b0;
      mac_d     = 1'b0;
      bias_d    = 1'b0;
      we_d      = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               in_nxt    = '0;
               out_nxt   = '0;
               state_nxt = MASK;
            end
         end
         MASK: begin
            busy_d = 1'b1;
            req_d  = 1'b1;
            // mask_load is the one output that follows mask_ack in the
            // same cycle, so the shares are captured as soon as offered.
            if (mask_ack) begin
               load_d    = 1'b1;
               state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            busy_d    = 1'b1;
            clr_d     = 1'b1;
            in_nxt    = '0;
            state_nxt = MAC;
         end
         MAC: begin
            busy_d = 1'b1;
            // A held cycle neither accumulates nor advances, so each
            // index gets exactly one accumulate cycle.
            if (!hold) begin
               mac_d = 1'b1;
               if (in_cnt == LAST_IN) begin
                  in_nxt    = '0;
                  state_nxt = BIAS;
               end else begin
                  in_nxt = in_cnt + IDX_ONE;
               end
            end
         end
         BIAS: begin
            busy_d    = 1'b1;
            bias_d    = 1'b1;
            state_nxt = WRITE;
         end
         WRITE: begin
            busy_d = 1'b1;
            we_d   = 1'b1;
            if (out_cnt == LAST_OUT) begin
               state_nxt = DONE;
            end else begin
               out_nxt   = out_cnt + IDX_ONE;
               state_nxt = MASK;
            end
         end
         DONE: begin
            done_d    = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Strobes are forced low in any cycle where rst is high so that an
   // abort suppresses a pending write or done pulse immediately.
   assign busy      = busy_d & ~rst;
   assign done      = done_d & ~rst;
   assign mask_req  = req_d  & ~rst;
   assign mask_load = load_d & ~rst;
   assign mac_clr   = clr_d  & ~rst;
   assign mac_en    = mac_d  & ~rst;
   assign bias_en   = bias_d & ~rst;
   assign out_we    = we_d   & ~rst;
   assign in_idx    = in_cnt;
   assign out_idx   = out_cnt;

endmodule
`default_nettype wire

// File: tb/tb_layer_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_layer_seq_ctrl
// Purpose  : Directed self-checking bench for layer_seq_ctrl (default sizes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_layer_seq_ctrl;

   localparam int IN_N   = 10;
   localparam int OUT_N  = 10;
   localparam int W      = 4;
   localparam int BUDGET = 400;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         hold = 1'b0;
   logic         mask_ack = 1'b1;
   logic         busy, done, mask_req, mask_load, mac_clr, mac_en, bias_en, out_we;
   logic [W-1:0] in_idx, out_idx;
   logic [7:0]   strobes;

   assign strobes = {busy, done, mask_req, mask_load, mac_clr, mac_en, bias_en, out_we};

   always #5 clk = ~clk;

   layer_seq_ctrl #(.INPUT_SIZE(IN_N), .OUTPUT_SIZE(OUT_N), .IDX_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .hold      (hold),
      .mask_ack  (mask_ack),
      .busy      (busy),
      .done      (done),
      .mask_req  (mask_req),
      .mask_load (mask_load),
      .mac_clr   (mac_clr),
      .mac_en    (mac_en),
      .bias_en   (bias_en),
      .out_we    (out_we),
      .in_idx    (in_idx),
      .out_idx   (out_idx)
   );

   int total = 0;
   int bad   = 0;
   int c_mac, c_clr, c_bias, c_load, c_req, c_we, c_done, c_busy;
   int lat;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Runs one evaluation from IDLE. Latency is the number of edges from the
   // start-sampling edge to the edge that captures done.
   task automatic run(input int stall_nr, input int stall_len,
                      input int hold_nr, input int hold_ix, input int hold_len,
                      input int rst_nr, input bit inject, output int latency);
      int exp_in, exp_out, stalls, holds, abort_n, waits;
      bit aborted;
      exp_in = 0; exp_out = 0; stalls = 0; holds = 0; abort_n = 0; aborted = 0;
      latency = -1;
      c_mac = 0; c_clr = 0; c_bias = 0; c_load = 0; c_req = 0; c_we = 0; c_done = 0; c_busy = 0;

      @(negedge clk);
      waits = 0;
      while ((busy || done) && waits < 10) begin
         @(negedge clk);
         waits++;
      end
      start = 1'b1;
      @(posedge clk);
      for (int n = 0; n < BUDGET; n++) begin
         @(negedge clk);
         start    = inject && (n == 20 || n == 80);
         rst      = 1'b0;
         mask_ack = 1'b1;
         hold     = 1'b0;
         if (mask_req && out_idx == stall_nr && stalls < stall_len) begin
            mask_ack = 1'b0;
            stalls++;
         end
         if (busy && out_idx == hold_nr && in_idx == hold_ix && holds < hold_len) begin
            hold = 1'b1;
            holds++;
         end
         if (rst_nr >= 0 && !aborted && out_we && out_idx == rst_nr) begin
            rst     = 1'b1;
            aborted = 1'b1;
            abort_n = n;
         end
         #1;
         if (rst) check("rst_strobes", strobes, 0);
         if (aborted && n == abort_n + 1) check("abort_idle", {strobes, in_idx, out_idx}, 0);
         if (hold) begin
            check("hold_mac_en", mac_en, 0);
            check("hold_in_idx", in_idx, hold_ix);
         end
         if (mac_en) begin
            check("mac_in_idx", in_idx, exp_in);
            exp_in++;
            c_mac++;
         end
         if (bias_en) begin
            check("mac_steps", exp_in, IN_N);
            exp_in = 0;
            c_bias++;
         end
         if (out_we) begin
            check("we_out_idx", out_idx, exp_out);
            exp_out++;
            c_we++;
         end
         if (mac_clr)   c_clr++;
         if (mask_load) c_load++;
         if (mask_req)  c_req++;
         if (busy)      c_busy++;
         if (done) begin
            c_done++;
            latency = n + 1;
            break;
         end
         if (aborted && n == abort_n + 20) break;
         @(posedge clk);
      end
      start = 1'b0;
      hold  = 1'b0;
      mask_ack = 1'b1;
   endtask

   initial begin
      // Reset held for 3 cycles, then 10 idle cycles with start low.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("reset_outputs", {strobes, in_idx, out_idx}, 0);
      end
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_outputs", {strobes, in_idx, out_idx}, 0);
      end

      // Nominal run.
      run(-1, 0, -1, 0, 0, -1, 0, lat);
      check("nom_latency", lat, 141);
      check("nom_mac_en", c_mac, 100);
      check("nom_mac_clr", c_clr, 10);
      check("nom_bias_en", c_bias, 10);
      check("nom_mask_load", c_load, 10);
      check("nom_mask_req", c_req, 10);
      check("nom_out_we", c_we, 10);
      check("nom_busy", c_busy, 140);
      check("nom_done", c_done, 1);

      // Mask backpressure: 5 stall cycles on neuron 3.
      run(3, 5, -1, 0, 0, -1, 0, lat);
      check("mask_latency", lat, 146);
      check("mask_req_cycles", c_req, 15);
      check("mask_load", c_load, 10);
      check("mask_mac_en", c_mac, 100);
      check("mask_busy", c_busy, 145);

      // Hold for 3 cycles at in_idx 4 of neuron 0.
      run(-1, 0, 0, 4, 3, -1, 0, lat);
      check("hold_latency", lat, 144);
      check("hold_mac_total", c_mac, 100);
      check("hold_out_we", c_we, 10);

      // start pulses while busy are ignored.
      run(-1, 0, -1, 0, 0, -1, 1, lat);
      check("busy_start_latency", lat, 141);
      check("busy_start_done", c_done, 1);
      check("busy_start_we", c_we, 10);
      // Now in the DONE cycle: a start here must be ignored.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      check("start_in_done_busy", busy, 0);
      check("start_in_done_done", done, 0);
      run(-1, 0, -1, 0, 0, -1, 0, lat);
      check("after_done_latency", lat, 141);

      // Reset during the write of neuron 5 aborts the run.
      run(-1, 0, -1, 0, 0, 5, 0, lat);
      check("abort_out_we", c_we, 5);
      check("abort_done", c_done, 0);
      run(-1, 0, -1, 0, 0, -1, 0, lat);
      check("post_abort_latency", lat, 141);
      check("post_abort_out_we", c_we, 10);
      check("post_abort_mac_en", c_mac, 100);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
